// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte-stream requesters.
// Round-robin arbitration, whole-packet grant lock, optional channel header byte,
// start-timeout recovery, MAX_BYTES truncation and a programmable inter-packet gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int GAP_CYCLES    = 10,
  parameter int HDR_EN        = 1,
  parameter int MAX_BYTES     = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           uart_data,
  output logic                 uart_send,
  input  logic                 uart_busy,
  output logic                 err_pulse,
  output logic [2:0]           debug_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = $clog2(MAX_BYTES + 1);
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARB        = 3'd1,
    HDR        = 3'd2,
    LOAD       = 3'd3,
    SEND       = 3'd4,
    WAIT_START = 3'd5,
    WAIT_DONE  = 3'd6,
    GAP        = 3'd7
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [BC_W-1:0]    byte_cnt, bc_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               last_flag, last_nxt;
  logic               trunc_flag, trunc_nxt;
  logic               hdr_phase, hdr_nxt;
  logic               busy_q;
  logic [NUM_REQ-1:0] grant_nxt, ready_nxt;
  logic [7:0]         data_nxt;
  logic               send_nxt, err_nxt, byte_done;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               at_cap;

  assign debug_state = state;
  assign at_cap      = (byte_cnt == BC_W'(MAX_BYTES - 1));

  // Round-robin search: first valid requester at or after rr_ptr, wrapping around.
  always_comb begin : pick_search
    logic [IDX_W-1:0] j;
    j          = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = j;
      end
    end
  end

  // Next-state and datapath updates; a completed byte (real or timed out) is routed at the end.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    bc_nxt    = byte_cnt;
    tmo_nxt   = tmo_cnt;
    gap_nxt   = gap_cnt;
    last_nxt  = last_flag;
    trunc_nxt = trunc_flag;
    hdr_nxt   = hdr_phase;
    grant_nxt = grant;
    data_nxt  = uart_data;
    send_nxt  = 1'b0;
    ready_nxt = '0;
    err_nxt   = 1'b0;
    byte_done = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) state_nxt = ARB;
      end
      ARB: begin
        if (pick_found) begin
          owner_nxt = pick_idx;
          grant_nxt = NUM_REQ'(1) << pick_idx;
          rr_nxt    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          bc_nxt    = '0;
          hdr_nxt   = 1'b0;
          state_nxt = (HDR_EN != 0) ? HDR : LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HDR: begin
        data_nxt  = 8'hA0 | 8'(owner);
        hdr_nxt   = 1'b1;
        state_nxt = SEND;
      end
      LOAD: begin
        if (req_valid[owner]) begin
          data_nxt         = req_data[{owner, 3'b000} +: 8];
          ready_nxt[owner] = 1'b1;
          last_nxt         = req_last[owner] | at_cap;
          trunc_nxt        = at_cap & ~req_last[owner];
          bc_nxt           = byte_cnt + 1'b1;
          state_nxt        = SEND;
        end
      end
      SEND: begin
        if (!uart_busy) begin
          send_nxt  = 1'b1;
          tmo_nxt   = '0;
          state_nxt = WAIT_START;
        end
      end
      WAIT_START: begin
        if (uart_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          byte_done = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (busy_q && !uart_busy) byte_done = 1'b1;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
        else gap_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (byte_done) begin
      if (hdr_phase || !last_flag) begin
        hdr_nxt   = 1'b0;
        state_nxt = LOAD;
      end else begin
        grant_nxt = '0;
        gap_nxt   = '0;
        state_nxt = GAP;
        if (trunc_flag) err_nxt = 1'b1;
      end
    end
  end

  // State, counters and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      last_flag  <= 1'b0;
      trunc_flag <= 1'b0;
      hdr_phase  <= 1'b0;
      busy_q     <= 1'b0;
      grant      <= '0;
      req_ready  <= '0;
      uart_data  <= 8'h00;
      uart_send  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_nxt;
      byte_cnt   <= bc_nxt;
      tmo_cnt    <= tmo_nxt;
      gap_cnt    <= gap_nxt;
      last_flag  <= last_nxt;
      trunc_flag <= trunc_nxt;
      hdr_phase  <= hdr_nxt;
      busy_q     <= uart_busy;
      grant      <= grant_nxt;
      req_ready  <= ready_nxt;
      uart_data  <= data_nxt;
      uart_send  <= send_nxt;
      err_pulse  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (3 requesters, header on, 16-byte cap).
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 4;
  localparam int BOUND    = 4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  uart_data;
  logic        uart_send;
  logic        uart_busy;
  logic        err_pulse;
  logic [2:0]  debug_state;

  int checks = 0;
  int failures = 0;

  logic [8:0] rq0[$], rq1[$], rq2[$];
  logic [7:0] logq[$];
  logic [2:0] logg[$];
  logic [7:0] expB[$];
  logic [2:0] expG[$];

  logic stuck = 1'b0;
  int   busy_left = 0;
  int   cyc = 0;
  int   last_send_cyc = 0;
  int   err_cnt = 0;
  int   err_lat = 0;
  int   viol = 0;
  int   gap_run = 0;
  int   last_gap = 0;
  int   rdy_cnt[3] = '{0, 0, 0};

  uart_tx_arbiter #(
    .NUM_REQ(3), .GAP_CYCLES(10), .HDR_EN(1), .MAX_BYTES(16), .START_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .uart_data(uart_data), .uart_send(uart_send), .uart_busy(uart_busy),
    .err_pulse(err_pulse), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  // Requester queues, uart_tx busy model and monitors, all updated on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      uart_busy = 1'b0;
      busy_left = 0;
    end else begin
      if (err_pulse) begin
        err_cnt++;
        err_lat = cyc - last_send_cyc;
      end
      if (grant != 3'd0 && (grant & (grant - 3'd1)) != 3'd0) viol++;
      if (debug_state == 3'd7) gap_run++;
      else if (gap_run != 0) begin
        last_gap = gap_run;
        gap_run  = 0;
      end
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) uart_busy = 1'b0;
      end
      if (uart_send) begin
        logq.push_back(uart_data);
        logg.push_back(grant);
        last_send_cyc = cyc;
        if (!stuck) begin
          uart_busy = 1'b1;
          busy_left = BUSY_LEN;
        end
      end
      if (req_ready[0]) begin rdy_cnt[0]++; if (rq0.size() > 0) rq0.delete(0); end
      if (req_ready[1]) begin rdy_cnt[1]++; if (rq1.size() > 0) rq1.delete(0); end
      if (req_ready[2]) begin rdy_cnt[2]++; if (rq2.size() > 0) rq2.delete(0); end
    end
    req_valid[0]    = (rq0.size() > 0);
    req_data[7:0]   = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
    req_last[0]     = (rq0.size() > 0) && rq0[0][8];
    req_valid[1]    = (rq1.size() > 0);
    req_data[15:8]  = (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
    req_last[1]     = (rq1.size() > 0) && rq1[0][8];
    req_valid[2]    = (rq2.size() > 0);
    req_data[23:16] = (rq2.size() > 0) ? rq2[0][7:0] : 8'h00;
    req_last[2]     = (rq2.size() > 0) && rq2[0][8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushReq(input int ch, input logic [7:0] b, input logic l);
    case (ch)
      0: rq0.push_back({l, b});
      1: rq1.push_back({l, b});
      default: rq2.push_back({l, b});
    endcase
  endtask

  task automatic addExp(input logic [7:0] b, input logic [2:0] g);
    expB.push_back(b);
    expG.push_back(g);
  endtask

  task automatic applyReset();
    rq0.delete(); rq1.delete(); rq2.delete();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  // Wait until n bytes were logged and the arbiter has drained back to IDLE.
  task automatic waitIdle(input string tag, input int n);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!(logq.size() >= n && debug_state == 3'd0 &&
             rq0.size() == 0 && rq1.size() == 0 && rq2.size() == 0) && t < BOUND) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_finished"}, 32'(t < BOUND), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int base);
    chk({tag, "_len"}, 32'(logq.size() - base), 32'(expB.size()));
    for (int k = 0; k < expB.size(); k++) begin
      chk($sformatf("%s_byte%0d", tag, k),
          (base + k < logq.size()) ? 32'(logq[base + k]) : 32'hFFFF_FFFF, 32'(expB[k]));
      chk($sformatf("%s_grant%0d", tag, k),
          (base + k < logg.size()) ? 32'(logg[base + k]) : 32'hFFFF_FFFF, 32'(expG[k]));
    end
    expB.delete();
    expG.delete();
  endtask

  initial begin
    int base, e0, r0, t;

    // Reset values
    reset_n = 1'b0;
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_send", 32'(uart_send), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_state", 32'(debug_state), 32'd0);
    chk("rst_data", 32'(uart_data), 32'd0);
    applyReset();

    // Single channel packet with header
    $display("[TB] single channel packet");
    base = logq.size();
    pushReq(0, 8'h35, 1'b0);
    pushReq(0, 8'h00, 1'b0);
    pushReq(0, 8'h18, 1'b0);
    pushReq(0, 8'h00, 1'b1);
    waitIdle("single", base + 5);
    addExp(8'hA0, 3'b001); addExp(8'h35, 3'b001); addExp(8'h00, 3'b001);
    addExp(8'h18, 3'b001); addExp(8'h00, 3'b001);
    checkOutput("single", base);
    chk("single_ready_cnt", 32'(rdy_cnt[0]), 32'd4);
    chk("single_gap_len", 32'(last_gap), 32'd10);
    chk("single_grant_idle", 32'(grant), 32'd0);
    chk("single_no_err", 32'(err_cnt), 32'd0);

    // All three channels at once after reset: ch0, ch1, ch2 in order
    $display("[TB] simultaneous requests");
    applyReset();
    @(posedge clk); #1;
    base = logq.size();
    pushReq(0, 8'h10, 1'b0); pushReq(0, 8'h11, 1'b1);
    pushReq(1, 8'h20, 1'b1);
    pushReq(2, 8'h30, 1'b0); pushReq(2, 8'h31, 1'b1);
    waitIdle("rr3", base + 8);
    addExp(8'hA0, 3'b001); addExp(8'h10, 3'b001); addExp(8'h11, 3'b001);
    addExp(8'hA1, 3'b010); addExp(8'h20, 3'b010);
    addExp(8'hA2, 3'b100); addExp(8'h30, 3'b100); addExp(8'h31, 3'b100);
    checkOutput("rr3", base);

    // Channel 1 re-requests right away while channel 2 waits
    $display("[TB] fairness");
    base = logq.size();
    pushReq(1, 8'h41, 1'b1); pushReq(1, 8'h42, 1'b1);
    pushReq(2, 8'h51, 1'b1);
    waitIdle("fair", base + 6);
    addExp(8'hA1, 3'b010); addExp(8'h41, 3'b010);
    addExp(8'hA2, 3'b100); addExp(8'h51, 3'b100);
    addExp(8'hA1, 3'b010); addExp(8'h42, 3'b010);
    checkOutput("fair", base);

    // uart_busy never rises: every byte times out and the FSM keeps going
    $display("[TB] start timeout");
    stuck = 1'b1;
    base = logq.size();
    e0 = err_cnt;
    r0 = rdy_cnt[0];
    pushReq(0, 8'h60, 1'b0); pushReq(0, 8'h61, 1'b1);
    waitIdle("tmo", base + 3);
    stuck = 1'b0;
    addExp(8'hA0, 3'b001); addExp(8'h60, 3'b001); addExp(8'h61, 3'b001);
    checkOutput("tmo", base);
    chk("tmo_err_cnt", 32'(err_cnt - e0), 32'd3);
    chk("tmo_latency", 32'(err_lat), 32'd8);
    chk("tmo_ready_cnt", 32'(rdy_cnt[0] - r0), 32'd2);

    // 20 bytes with last only on the 20th: cut at 16, remainder gets a fresh header
    $display("[TB] truncation");
    base = logq.size();
    e0 = err_cnt;
    r0 = rdy_cnt[0];
    for (int k = 0; k < 20; k++) pushReq(0, 8'(8'h80 + k), (k == 19));
    waitIdle("trunc", base + 22);
    addExp(8'hA0, 3'b001);
    for (int k = 0; k < 16; k++) addExp(8'(8'h80 + k), 3'b001);
    addExp(8'hA0, 3'b001);
    for (int k = 16; k < 20; k++) addExp(8'(8'h80 + k), 3'b001);
    checkOutput("trunc", base);
    chk("trunc_err_cnt", 32'(err_cnt - e0), 32'd1);
    chk("trunc_ready_cnt", 32'(rdy_cnt[0] - r0), 32'd20);

    // Asynchronous reset while byte 2 of a packet is on the wire
    $display("[TB] async reset mid-packet");
    base = logq.size();
    pushReq(1, 8'h70, 1'b0); pushReq(1, 8'h71, 1'b0); pushReq(1, 8'h72, 1'b1);
    t = 0;
    while (!(logq.size() >= base + 2 && debug_state == 3'd6) && t < BOUND) begin
      @(posedge clk); #1;
      t++;
    end
    chk("areset_reached_wait_done", 32'(t < BOUND), 32'd1);
    chk("areset_grant_before", 32'(grant), 32'b010);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_grant", 32'(grant), 32'd0);
    chk("areset_send", 32'(uart_send), 32'd0);
    chk("areset_ready", 32'(req_ready), 32'd0);
    chk("areset_state", 32'(debug_state), 32'd0);
    chk("areset_data", 32'(uart_data), 32'd0);
    rq0.delete(); rq1.delete(); rq2.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("areset_idle", 32'(debug_state), 32'd0);

    // rr_ptr restarted at 0: ch0 beats ch2
    base = logq.size();
    pushReq(0, 8'h01, 1'b1);
    pushReq(2, 8'h02, 1'b1);
    waitIdle("post_reset", base + 4);
    addExp(8'hA0, 3'b001); addExp(8'h01, 3'b001);
    addExp(8'hA2, 3'b100); addExp(8'h02, 3'b100);
    checkOutput("post_reset", base);

    chk("grant_onehot", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
